mips_control_alu: RTL and testbench



---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mips_alu_core.sv | 32 +++
 rtl/mips_control_alu.sv | 102 ++++++++++
 tb/tb_mips_control_alu.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute-stage control and ALU.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned ALUCTL_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALUCTL_W-1:0] ALU_SRL = 4'b0100;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUCTL_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_IMM    = 2'b11;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_core.sv
// Purely combinational 32-bit ALU with zero detect.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [ALUCTL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]    result,
  output logic                zero
);

  always_comb begin
    result = '0;
    unique case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = WIDTH'($signed(a) < $signed(b));
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_control_alu.sv
// Execute-stage main decode, ALU control decode and registered ALU result.
module mips_control_alu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic                en,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                reg_dst,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_to_reg,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_write,
  output logic [ALUOP_W-1:0]  alu_op_out,
  output logic [ALUCTL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]    result,
  output logic                zero
);

  ctrl_t            ctrl;
  logic [WIDTH-1:0] aluResult;
  logic             aluZero;

  // Main decode; unknown opcodes fall through to an all-zero NOP.
  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: ctrl = '{reg_dst: 1'b1, reg_write: 1'b1, alu_op: ALUOP_RTYPE, default: '0};
      OP_LW:    ctrl = '{alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1, mem_read: 1'b1,
                         alu_op: ALUOP_MEM, default: '0};
      OP_SW:    ctrl = '{alu_src: 1'b1, mem_write: 1'b1, alu_op: ALUOP_MEM, default: '0};
      OP_BEQ:   ctrl = '{branch: 1'b1, alu_op: ALUOP_BRANCH, default: '0};
      OP_ADDI:  ctrl = '{alu_src: 1'b1, reg_write: 1'b1, alu_op: ALUOP_MEM, default: '0};
      default:  ctrl = '0;
    endcase
  end

  assign reg_dst    = ctrl.reg_dst;
  assign alu_src    = ctrl.alu_src;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign branch     = ctrl.branch;
  assign alu_op_out = ctrl.alu_op;

  // ALU control; unrecognised funct codes default to ADD.
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_IMM:    alu_ctrl = ALU_ADD;
      ALUOP_RTYPE: begin
        unique case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SRL:  alu_ctrl = ALU_SRL;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default:      alu_ctrl = ALU_ADD;
    endcase
  end

  mips_alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a       (a),
    .b       (b),
    .shamt   (shamt),
    .alu_ctrl(alu_ctrl),
    .result  (aluResult),
    .zero    (aluZero)
  );

  // Reset value mirrors a zero result so zero stays consistent with result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (en) begin
      result <= aluResult;
      zero   <= aluZero;
    end
  end

endmodule

// File: tb/tb_mips_control_alu.sv
// Directed self-checking bench for mips_control_alu.
module tb_mips_control_alu;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [1:0]  alu_op;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op_out;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;

  int nAssert;
  int nFail;

  mips_control_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .shamt     (shamt),
    .alu_op    (alu_op),
    .en        (en),
    .a         (a),
    .b         (b),
    .reg_dst   (reg_dst),
    .branch    (branch),
    .mem_read  (mem_read),
    .mem_to_reg(mem_to_reg),
    .mem_write (mem_write),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .alu_op_out(alu_op_out),
    .alu_ctrl  (alu_ctrl),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one EX-stage operation, check alu_ctrl, then the registered result and zero.
  task automatic aluStep(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv,
                         input logic [3:0] expCtrl, input logic [31:0] expRes);
    @(negedge clk);
    alu_op = op; funct = fn; shamt = sh; a = av; b = bv; en = 1'b1;
    #1;
    chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(expCtrl));
    @(posedge clk);
    #1;
    chk({tag, "_res"}, result, expRes);
    chk({tag, "_zero"}, 32'(zero), 32'(expRes == 32'h0));
  endtask

  task automatic ctrlStep(input string tag, input logic [5:0] op, input logic [8:0] expVec);
    opcode = op;
    #1;
    chk(tag, 32'({reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
                  alu_op_out}), 32'(expVec));
  endtask

  initial begin
    nAssert = 0;
    nFail   = 0;
    rst_n = 1'b1; en = 1'b0; opcode = 6'h00; funct = 6'h20; shamt = 5'd0;
    alu_op = 2'b00; a = 32'd0; b = 32'd0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    aluStep("first_add", 2'b00, 6'h00, 5'd0, 32'd5, 32'd3, 4'b0010, 32'd8);

    // Main decode sweep: reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,aluop.
    @(negedge clk);
    ctrlStep("dec_rtype", 6'h00, 9'b1_0_0_1_0_0_0_10);
    ctrlStep("dec_lw",    6'h23, 9'b0_1_1_1_1_0_0_00);
    ctrlStep("dec_sw",    6'h2B, 9'b0_1_0_0_0_1_0_00);
    ctrlStep("dec_beq",   6'h04, 9'b0_0_0_0_0_0_1_01);
    ctrlStep("dec_addi",  6'h08, 9'b0_1_0_1_0_0_0_00);
    ctrlStep("dec_nop",   6'h3F, 9'b0);

    aluStep("sub_eq",   2'b10, 6'h22, 5'd0, 32'd7, 32'd7, 4'b0110, 32'h0);
    aluStep("slt_neg",  2'b10, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'h1);
    aluStep("slt_pos",  2'b10, 6'h2A, 5'd0, 32'd1, 32'hFFFFFFFF, 4'b0111, 32'h0);
    aluStep("nor",      2'b10, 6'h27, 5'd0, 32'h0F0F, 32'h00FF, 4'b1100, 32'hFFFFF000);
    aluStep("and",      2'b10, 6'h24, 5'd0, 32'hF0F0, 32'hFF00, 4'b0000, 32'hF000);
    aluStep("or",       2'b10, 6'h25, 5'd0, 32'hF0F0, 32'h0F00, 4'b0001, 32'hFFF0);
    aluStep("sll",      2'b10, 6'h00, 5'd4, 32'h0, 32'h80000001, 4'b0011, 32'h00000010);
    aluStep("srl",      2'b10, 6'h02, 5'd4, 32'h0, 32'h80000001, 4'b0100, 32'h08000000);
    aluStep("imm_add",  2'b11, 6'h22, 5'd0, 32'd2, 32'd3, 4'b0010, 32'd5);
    aluStep("br_sub",   2'b01, 6'h25, 5'd0, 32'd10, 32'd4, 4'b0110, 32'd6);
    aluStep("unk_fn",   2'b10, 6'h3F, 5'd0, 32'd1, 32'd2, 4'b0010, 32'd3);
    aluStep("add_wrap", 2'b10, 6'h20, 5'd0, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'h0);

    // Enable low: register holds across several edges while operands change.
    @(negedge clk);
    en = 1'b0; alu_op = 2'b00; a = 32'd5; b = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_res%0d", i), result, 32'h0);
      chk($sformatf("hold_zero%0d", i), 32'(zero), 32'h1);
    end

    // Mid-operation reset clears without a clock edge and dominates a clocked capture.
    aluStep("pre_rst", 2'b00, 6'h00, 5'd0, 32'd5, 32'd3, 4'b0010, 32'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", result, 32'h0);
    chk("mid_rst_zero", 32'(zero), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_hold_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_res", result, 32'd8);
    chk("post_rst_zero", 32'(zero), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
